ena_stream_fifo: RTL
====================

// Module: ena_stream_fifo
// PURPOSE
//   Downstream stage for the 16-bit rotate register. Captures every word qualified
//   by ena_in into a small synchronous FIFO and re-presents it on a valid/ready
//   interface, so consumers can apply backpressure. The upstream stage has no ready.
//   Overflow therefore drops the word and raises a sticky flag.
// PARAMETERS
//   WIDTH   16   data width of bus_in / bus_out
//   DEPTH   8    FIFO entries; power of two, >= 2
//   LW      $clog2(DEPTH)+1   level width (localparam, not overridable)
// PORTS
//   clk        in   1      single clock, all logic on posedge
//   rst_n      in   1      synchronous reset, active-low
//   bus_in     in   WIDTH  data word from upstream rotate stage
//   ena_in     in   1      bus_in valid this cycle (push request)
//   bus_out    out  WIDTH  head-of-FIFO data
//   valid_out  out  1      bus_out holds a valid word
//   ready_in   in   1      consumer accepts bus_out this cycle
//   level      out  LW     number of words stored, 0..DEPTH
//   full       out  1      level == DEPTH
//   ovf        out  1      sticky: a push was dropped
//   ovf_clr    in   1      clears ovf (synchronous)
// BEHAVIOUR
//   Reset (rst_n==0 at posedge)
//   - level=0, full=0, valid_out=0, ovf=0, rd/wr pointers=0.
//   - bus_out=0; storage contents are not reset.
//   - Reset mid-stream discards all stored words; no pop is signalled that cycle.
//   Push / pop (evaluated each posedge with rst_n==1)
//   - push = ena_in; pop = valid_out & ready_in.
//   - Push accepted when (level<DEPTH) or pop. A pop on a full FIFO frees a slot
//     in the same cycle.
//   - Push while full with no pop: word dropped, ovf<=1, level unchanged.
//   - level next = level + accepted_push - pop.
//   - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
//   Output timing (first-word-fall-through, registered)
//   - bus_out/valid_out are registers. Word pushed at edge N into an empty FIFO
//     shows valid_out=1 from edge N+1; there is no same-cycle bypass.
//   - After a pop at edge N, the next word (if any) is on bus_out from edge N+1.
//   - valid_out=1 iff level>0 after the edge, so back-to-back pops give 1 word/clk.
//   - bus_out holds its value while valid_out=1 and ready_in=0. Data is in-order,
//     bit-exact, and is never altered.
//   - Pop on empty is impossible: pop requires valid_out=1.
//   - Simultaneous push+pop at level==1: level stays 1, new word becomes head.
//   Flags
//   - full is combinational from level, or registered; either way it must equal
//     (level==DEPTH) in the same cycle.
//   - ovf set has priority over ovf_clr in the same cycle.
//   - ovf_clr alone clears ovf at the next edge.
// TESTING
//   1 Reset: hold rst_n=0 3 clks with ena_in=1 -> level=0, valid_out=0, ovf=0,
//     bus_out=16'h0000.
//   2 Latency: push 16'hA5A5 at edge N, ready_in=1 -> valid_out=1 and
//     bus_out=16'hA5A5 from edge N+1; popped at edge N+1; level back to 0 at N+2.
//   3 Fill/wrap: ready_in=0, push 8 words 16'h0001..16'h0008 -> full=1, level=8.
//     Then ready_in=1 with pushes 16'h0009.. continuing -> output sequence
//     0001,0002,... with no gaps, across pointer wrap.
//   4 Overflow: full, ready_in=0, push 16'hDEAD -> ovf=1, level=8, DEAD never
//     appears on the output. Same cycle ovf_clr=1 -> ovf stays 1. Next cycle
//     ovf_clr=1 alone -> ovf=0.
//   5 Full push+pop: level=8, ena_in=1 with 16'hBEEF, ready_in=1 -> ovf stays 0,
//     level stays 8, BEEF emerges 8 pops later.
//   6 Reset mid-stream: level=5, deassert rst_n one clk -> level=0, valid_out=0.
//     Subsequent push 16'h1234 is the first word out.

Source files
------------

// File: rtl/ena_stream_fifo_if.sv
// Valid/ready stream bundle between the rotate stage, the FIFO and its consumer.
interface ena_stream_fifo_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] bus_in;
    logic             ena_in;
    logic [WIDTH-1:0] bus_out;
    logic             valid_out;
    logic             ready_in;

    // FIFO side: accepts pushes, presents the head word
    modport slave (
        input  bus_in,
        input  ena_in,
        input  ready_in,
        output bus_out,
        output valid_out
    );

    // Environment side: drives pushes and consumer ready
    modport master (
        output bus_in,
        output ena_in,
        output ready_in,
        input  bus_out,
        input  valid_out
    );
endinterface

// File: rtl/ena_stream_fifo.sv
// First-word-fall-through FIFO that turns the ena-qualified rotate output into a
// valid/ready stream; pushes arriving while full are dropped and flagged in ovf.
module ena_stream_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ena_stream_fifo_if.slave     s,
    output logic [LW-1:0]        level,
    output logic                 full,
    output logic                 ovf,
    input  logic                 ovf_clr
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] bus_out_q, bus_out_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;

    logic pop_c;
    logic push_acc_c;

    // A pop on a full FIFO frees the slot the same cycle
    always_comb begin
        pop_c      = valid_q & s.ready_in;
        push_acc_c = s.ena_in & ((level_q != LW'(DEPTH)) | pop_c);
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        bus_out_d = bus_out_q;
        ovf_d     = ovf_q;

        if (push_acc_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        level_d = level_q + LW'(push_acc_c) - LW'(pop_c);

        // Head register: incoming word when it becomes the head, else next stored word
        if (push_acc_c && (level_q == LW'(pop_c))) begin
            bus_out_d = s.bus_in;
        end else if (pop_c && (level_q > LW'(1))) begin
            bus_out_d = mem_q[rd_ptr_q + PW'(1)];
        end

        // A dropped push wins over a clear in the same cycle
        if (s.ena_in && !push_acc_c) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end

        valid_d = (level_d != LW'(0));
        full_d  = (level_d == LW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            bus_out_q <= '0;
            valid_q   <= 1'b0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            bus_out_q <= bus_out_d;
            valid_q   <= valid_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage is not reset
    always_ff @(posedge clk) begin
        if (rst_n && push_acc_c) begin
            mem_q[wr_ptr_q] <= s.bus_in;
        end
    end

    assign s.bus_out   = bus_out_q;
    assign s.valid_out = valid_q;
    assign level       = level_q;
    assign full        = full_q;
    assign ovf         = ovf_q;
endmodule
